// File: rtl/sec32_check_encoder.sv
// -----------------------------------------------------------------------------
// sec32_check_encoder
//
// Streaming check-bit generator for the 32-bit SEC code consumed by the c499
// corrector. Each accepted data word is stored in a 2-entry FIFO together with
// its 8 check bits. An optional one-shot single-bit error can be injected into
// either the data or the check bits of a word as it is accepted.
//
// Handshake rules (both sides):
//   A transfer happens on a rising edge where valid & ready are both 1.
//   Once valid is raised, the payload is held stable until the transfer.
//   in_ready depends on registered state only. It never depends on out_ready.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     upstream word valid
//   in_ready     a word can be accepted (fewer than 2 words buffered)
//   in_data      data word d[31:0]
//   inj_req      one-cycle request to corrupt one bit of a word
//   inj_sel      bit to flip: 0-31 data, 32-39 check, 40-63 none
//   out_valid    FIFO head is valid
//   out_ready    downstream accepts
//   out_data     head data word (after optional injection)
//   out_check    head check bits c[7:0]
//   out_en       corrector check-enable, equal to out_valid
//   inj_pending  an injection is armed and not yet applied
//   word_count   number of output handshakes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module sec32_check_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             inj_req,
    input  logic [5:0]       inj_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_check,
    output logic             out_en,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_count
);

    // Check-bit equations of the c499 SEC code. Every check bit covers
    // one nibble-position group plus a byte-shaped group of data bits.
    function automatic logic [7:0] calc_check(input logic [31:0] d);
        logic [7:0] c;
        c[0] = ^{d[0],  d[4],  d[8],  d[12], d[23:16]};
        c[1] = ^{d[1],  d[5],  d[9],  d[13], d[31:24]};
        c[2] = ^{d[2],  d[6],  d[10], d[14], d[19:16], d[27:24]};
        c[3] = ^{d[3],  d[7],  d[11], d[15], d[23:20], d[31:28]};
        c[4] = ^{d[16], d[20], d[24], d[28], d[7:0]};
        c[5] = ^{d[17], d[21], d[25], d[29], d[15:8]};
        c[6] = ^{d[18], d[22], d[26], d[30], d[3:0],  d[11:8]};
        c[7] = ^{d[19], d[23], d[27], d[31], d[7:4],  d[15:12]};
        return c;
    endfunction

    logic [31:0]      mem_data_q  [2];
    logic [7:0]       mem_check_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             inj_pending_q;
    logic [5:0]       inj_sel_q;
    logic [CNT_W-1:0] word_count_q;

    logic             push;
    logic             pop;
    logic             inj_active;
    logic [5:0]       eff_sel;
    logic [31:0]      wr_data;
    logic [7:0]       wr_check;

    assign in_ready = (count_q != 2'd2);
    // Forced low while rst_n is asserted, so a reset cycle never pops a word.
    assign out_valid = rst_n & (count_q != 2'd0);
    assign out_en    = out_valid;
    assign out_data  = out_valid ? mem_data_q[rd_ptr_q]  : 32'd0;
    assign out_check = out_valid ? mem_check_q[rd_ptr_q] : 8'd0;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign inj_pending = inj_pending_q;
    assign word_count  = word_count_q;

    // A request in the current cycle takes precedence over the latched one.
    assign inj_active = inj_req | inj_pending_q;
    assign eff_sel    = inj_req ? inj_sel : inj_sel_q;

    // Check bits always come from the clean data; the flip happens afterwards
    // so the stored word carries a genuine single-bit error.
    always_comb begin
        wr_data  = in_data;
        wr_check = calc_check(in_data);
        if (inj_active) begin
            if (eff_sel < 6'd32) begin
                wr_data[eff_sel[4:0]] = ~in_data[eff_sel[4:0]];
            end else if (eff_sel < 6'd40) begin
                wr_check[eff_sel[2:0]] = ~wr_check[eff_sel[2:0]];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_data_q[0]  <= 32'd0;
            mem_data_q[1]  <= 32'd0;
            mem_check_q[0] <= 8'd0;
            mem_check_q[1] <= 8'd0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            inj_pending_q  <= 1'b0;
            inj_sel_q      <= 6'd0;
            word_count_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_data_q[wr_ptr_q]  <= wr_data;
                mem_check_q[wr_ptr_q] <= wr_check;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q     <= ~rd_ptr_q;
                word_count_q <= word_count_q + CNT_W'(1);
            end
            // An accepted word always consumes the injection, whether it came
            // from this cycle's request or an earlier latched one.
            if (push) begin
                inj_pending_q <= 1'b0;
            end else if (inj_req) begin
                inj_pending_q <= 1'b1;
                inj_sel_q     <= inj_sel;
            end
        end
    end

endmodule

// File: tb/tb_sec32_check_encoder.sv
module tb_sec32_check_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             inj_req;
    logic [5:0]       inj_sel;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [7:0]       out_check;
    logic             out_en;
    logic             inj_pending;
    logic [CNT_W-1:0] word_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_done;

    logic [39:0] exp_q[$];

    sec32_check_encoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .inj_req     (inj_req),
        .inj_sel     (inj_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_check   (out_check),
        .out_en      (out_en),
        .inj_pending (inj_pending),
        .word_count  (word_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_check(input logic [31:0] d);
        logic [31:0] m [8];
        logic [7:0]  c;
        m = '{32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
              32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0};
        for (int i = 0; i < 8; i++) c[i] = ^(d & m[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        in_valid = 1'b0;
        inj_req  = 1'b0;
    endtask

    // Offers a word until accepted; the expected output is queued on accept.
    task automatic drive_word(input logic [31:0] d, input logic [31:0] ed, input logic [7:0] ec);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int g = 0; g < 64 && !acc; g++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (acc) exp_q.push_back({ed, ec});
        else begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: word %08h not accepted", d);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int g = 0; g < 32 && exp_q.size() > 0; g++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 40'(exp_q.size()), 40'd0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %08h/%02h with empty queue", out_data, out_check);
            end else begin
                check("out_word", {out_data, out_check}, exp_q.pop_front());
                check("out_en", 40'(out_en), 40'd1);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] data;
        logic        inj;
        logic [5:0]  sel;
        logic [31:0] exp_data;
        logic [7:0]  exp_check;
    } vec_t;

    vec_t vecs [9];
    logic [31:0] w [4];
    logic [31:0] d;

    initial begin
        vecs[0] = '{32'h00000000, 1'b0, 6'd0,  32'h00000000, 8'h00};
        vecs[1] = '{32'h00000001, 1'b0, 6'd0,  32'h00000001, 8'h51};
        vecs[2] = '{32'h80000000, 1'b0, 6'd0,  32'h80000000, 8'h8A};
        vecs[3] = '{32'hFFFFFFFF, 1'b0, 6'd0,  32'hFFFFFFFF, 8'h00};
        vecs[4] = '{32'h00000000, 1'b1, 6'd32, 32'h00000000, 8'h01};
        vecs[5] = '{32'h00000000, 1'b1, 6'd5,  32'h00000020, 8'h00};
        vecs[6] = '{32'h00000001, 1'b1, 6'd50, 32'h00000001, 8'h51};
        vecs[7] = '{32'hFFFFFFFF, 1'b1, 6'd39, 32'hFFFFFFFF, 8'h80};
        vecs[8] = '{32'h00000000, 1'b1, 6'd31, 32'h80000000, 8'h00};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        inj_req   = 1'b0;
        inj_sel   = 6'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", 40'(out_valid), 40'd0);
        check("rst_out_en", 40'(out_en), 40'd0);
        check("rst_out_word", {out_data, out_check}, 40'd0);
        check("rst_inj_pending", 40'(inj_pending), 40'd0);
        check("rst_word_count", 40'(word_count), 40'd0);
        check("rst_in_ready", 40'(in_ready), 40'd1);

        // Table vectors, streamed back to back
        foreach (vecs[i]) begin
            inj_req = vecs[i].inj;
            inj_sel = vecs[i].sel;
            drive_word(vecs[i].data, vecs[i].exp_data, vecs[i].exp_check);
            check("latency_out_valid", 40'(out_valid), 40'd1);
        end
        idle();
        drain();
        check("table_word_count", 40'(word_count), 40'd9);
        check("table_inj_pending", 40'(inj_pending), 40'd0);

        // Injection armed ahead of the word
        inj_req = 1'b1;
        inj_sel = 6'd32;
        @(posedge clk);
        #1;
        inj_req = 1'b0;
        check("arm_pending", 40'(inj_pending), 40'd1);
        drive_word(32'd0, 32'd0, 8'h01);
        idle();
        check("consume_pending", 40'(inj_pending), 40'd0);

        // Newer request overwrites an older pending one
        inj_req = 1'b1;
        inj_sel = 6'd3;
        @(posedge clk);
        #1;
        inj_sel = 6'd39;
        @(posedge clk);
        #1;
        inj_req = 1'b0;
        check("overwrite_pending", 40'(inj_pending), 40'd1);
        drive_word(32'd0, 32'd0, 8'h80);
        idle();

        // Out-of-range selector arms but flips nothing
        inj_req = 1'b1;
        inj_sel = 6'd45;
        @(posedge clk);
        #1;
        inj_req = 1'b0;
        drive_word(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00);
        idle();

        // Same-cycle request applies directly and never arms
        inj_req = 1'b1;
        inj_sel = 6'd5;
        drive_word(32'd0, 32'h00000020, 8'h00);
        inj_req = 1'b0;
        idle();
        check("same_cycle_pending", 40'(inj_pending), 40'd0);
        drain();

        // Backpressure: two words fill the buffer, head held stable
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        out_ready = 1'b0;
        drive_word(w[0], w[0], model_check(w[0]));
        drive_word(w[1], w[1], model_check(w[1]));
        check("full_in_ready", 40'(in_ready), 40'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_head", {out_data, out_check}, {w[0], model_check(w[0])});
            check("hold_valid", 40'(out_valid), 40'd1);
        end
        @(posedge clk);
        #1;
        fork
            begin
                drive_word(w[2], w[2], model_check(w[2]));
                drive_word(w[3], w[3], model_check(w[3]));
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random data under random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    d = $urandom;
                    drive_word(d, d, model_check(d));
                end
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Reset mid-stream with full buffer and pending injection
        out_ready = 1'b0;
        drive_word(32'h12345678, 32'h12345678, model_check(32'h12345678));
        drive_word(32'hCAFEF00D, 32'hCAFEF00D, model_check(32'hCAFEF00D));
        idle();
        inj_req = 1'b1;
        inj_sel = 6'd7;
        @(posedge clk);
        #1;
        inj_req = 1'b0;
        check("pre_rst_pending", 40'(inj_pending), 40'd1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_out_valid", 40'(out_valid), 40'd0);
        check("mid_rst_out_en", 40'(out_en), 40'd0);
        check("mid_rst_pending", 40'(inj_pending), 40'd0);
        check("mid_rst_word_count", 40'(word_count), 40'd0);
        check("mid_rst_in_ready", 40'(in_ready), 40'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_empty", 40'(out_valid), 40'd0);

        // Counter wrap: 2^CNT_W + 1 handshakes
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            d = $urandom;
            drive_word(d, d, model_check(d));
        end
        idle();
        drain();
        check("wrap_word_count", 40'(word_count), 40'd1);

        check("final_queue_empty", 40'(exp_q.size()), 40'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
